// File: rtl/aes_key_expansion.sv
// ----------------------------------------------------------------------------
// aes_key_expansion
// Sequential AES-128 key schedule. A 128-bit cipher key is captured on start
// and round keys 0..10 are produced one per accepted valid/ready handshake.
// Each next key is derived on the fly from the current one; nothing is stored
// beyond the single round-key register.
//
// Ports
//   clk        in   1    system clock, rising edge
//   n_rst      in   1    asynchronous active-low reset
//   start      in   1    begin a schedule (sampled only in IDLE)
//   cipher_key in   128  AES key, w0 = [127:96] (sampled on accepted start)
//   key_ready  in   1    consumer accepts round_key this cycle
//   round_key  out  128  current round key, w0 = [127:96]
//   round_num  out  4    index of round_key, 0..10
//   key_valid  out  1    round_key / round_num valid
//   busy       out  1    schedule in progress
//   done       out  1    one-cycle pulse after round key 10 is accepted
// ----------------------------------------------------------------------------
module aes_key_expansion (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Shared AES S-box table, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte substitution; ~a*8 selects entry a counted from the MSB end.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        sbox = SBOX_TABLE[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for round index 1..10; other indices never used.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon_lookup = 8'h01;
            4'd2:    rcon_lookup = 8'h02;
            4'd3:    rcon_lookup = 8'h04;
            4'd4:    rcon_lookup = 8'h08;
            4'd5:    rcon_lookup = 8'h10;
            4'd6:    rcon_lookup = 8'h20;
            4'd7:    rcon_lookup = 8'h40;
            4'd8:    rcon_lookup = 8'h80;
            4'd9:    rcon_lookup = 8'h1b;
            4'd10:   rcon_lookup = 8'h36;
            default: rcon_lookup = 8'h00;
        endcase
    endfunction

    // One key-schedule step: S-box on the rotated last word, then a ripple
    // of four XORs across the words.
    function automatic logic [127:0] next_key(input logic [127:0] key,
                                              input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        temp = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   round_key_q, round_key_d;
    logic [3:0]     round_num_q, round_num_d;
    logic           key_valid_q, key_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-state and next-output computation for the schedule sequencer.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_num_d = round_num_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACTIVE;
                    round_key_d = cipher_key;
                    round_num_d = 4'd0;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    key_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ACTIVE: begin
                // key_valid is always high here, so key_ready alone is the handshake.
                if (key_ready) begin
                    if (round_num_q == LAST_ROUND) begin
                        state_d     = IDLE;
                        key_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        round_key_d = next_key(round_key_q,
                                               rcon_lookup(round_num_q + 4'd1));
                        round_num_d = round_num_q + 4'd1;
                    end
                end else begin
                    round_key_d = round_key_q;
                    round_num_d = round_num_q;
                end
            end
            default: begin
                state_d     = IDLE;
                key_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            round_key_q <= 128'd0;
            round_num_q <= 4'd0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_num_q <= round_num_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign round_key = round_key_q;
    assign round_num = round_num_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// ----------------------------------------------------------------------------
// tb_aes_key_expansion
// Directed bench for the AES-128 key schedule. Expected round keys come from
// an independent model (S-box derived from GF(2^8) inversion + affine map)
// pushed into a scoreboard at start; a monitor pops on every handshake.
// ----------------------------------------------------------------------------
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] cipher_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_key_expansion dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .cipher_key (cipher_key),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ALT_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct packed {
        logic [3:0]   rn;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    logic [7:0]   sbox_m [256];
    logic [127:0] model_keys [11];
    logic [127:0] seen_key [11];
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Build the S-box from first principles: inverse (x^254) then affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, v[7:0]);
            b = inv;
            sbox_m[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Word-wise FIPS-197 expansion; fills model_keys and the scoreboard.
    task automatic expand_push(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        exp_t        e;
        rc = 8'h01;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.rn  = r[3:0];
            e.key = model_keys[r];
            sb_q.push_back(e);
        end
    endtask

    task automatic clear_seen();
        for (int r = 0; r < 11; r++) seen_key[r] = 128'hx;
    endtask

    task automatic start_schedule(input logic [127:0] key);
        @(posedge clk); #1;
        cipher_key = key;
        start      = 1'b1;
        expand_push(key);
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Bounded wait for the done pulse; cycles counts negedges since return of start.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            checks++; failures++;
            $error("FAIL done_timeout observed=no_done expected=done_pulse");
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_valid && round_num == r) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++; failures++;
            $error("FAIL round_timeout observed=absent expected=round_%0d", r);
        end
    endtask

    initial begin
        int   cyc;
        exp_t e;
        n_rst = 1'b0; start = 1'b0; cipher_key = 128'd0; key_ready = 1'b0;
        build_sbox();
        clear_seen();
        #2;
        check("rst_round_key", round_key, 128'd0);
        check("rst_round_num", {124'd0, round_num}, 128'd0);
        check("rst_valid_busy_done", {125'd0, key_valid, busy, done}, 128'd0);
        @(negedge clk); #1 n_rst = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {125'd0, key_valid, busy, done}, 128'd0);

        // Scoreboard monitor: one pop per handshake seen at the falling edge.
        fork
            forever begin
                @(negedge clk);
                if (n_rst && key_valid && key_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $error("FAIL sb_underflow observed=round_%0d expected=no_handshake", round_num);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_round_num", {124'd0, round_num}, {124'd0, e.rn});
                        check("sb_round_key", round_key, e.key);
                    end
                    if (round_num <= 4'd10) seen_key[round_num] = round_key;
                end
            end
        join_none

        // 1: FIPS-197 key, no backpressure.
        key_ready = 1'b1;
        clear_seen();
        start_schedule(FIPS_KEY);
        wait_done(cyc);
        check("s1_done_latency", 128'(cyc), 128'd12);
        check("s1_busy_valid_at_done", {126'd0, busy, key_valid}, 128'd0);
        @(negedge clk);
        check("s1_done_one_cycle", {127'd0, done}, 128'd0);
        check("s1_r0", seen_key[0], FIPS_KEY);
        check("s1_r1", seen_key[1], FIPS_R1);
        check("s1_r2", seen_key[2], FIPS_R2);
        check("s1_r10", seen_key[10], FIPS_R10);
        check("s1_sb_empty", 128'(sb_q.size()), 128'd0);

        // 2: all-zero key.
        clear_seen();
        start_schedule(ZERO_KEY);
        wait_done(cyc);
        check("s2_r1", seen_key[1], ZERO_R1);
        check("s2_r10", seen_key[10], ZERO_R10);
        check("s2_sb_empty", 128'(sb_q.size()), 128'd0);

        // 3: three stall cycles while round 4 is presented.
        clear_seen();
        start_schedule(FIPS_KEY);
        wait_round(4'd3);
        @(posedge clk); #1 key_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("s3_stall_num", {124'd0, round_num}, 128'd4);
            check("s3_stall_key", round_key, model_keys[4]);
            check("s3_stall_valid", {127'd0, key_valid}, 128'd1);
        end
        @(posedge clk); #1 key_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("s3_round5_after_hs", {124'd0, round_num}, 128'd5);
        wait_done(cyc);
        check("s3_r10", seen_key[10], FIPS_R10);
        check("s3_sb_empty", 128'(sb_q.size()), 128'd0);

        // 4: start and a new key while busy are ignored.
        clear_seen();
        start_schedule(FIPS_KEY);
        wait_round(4'd6);
        @(posedge clk); #1 start = 1'b1; cipher_key = ALT_KEY;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("s4_busy_held", {127'd0, busy}, 128'd1);
        wait_done(cyc);
        check("s4_r10", seen_key[10], FIPS_R10);
        check("s4_sb_empty", 128'(sb_q.size()), 128'd0);

        // 5: asynchronous reset mid-schedule, then a fresh FIPS run.
        start_schedule(FIPS_KEY);
        wait_round(4'd7);
        #1 n_rst = 1'b0;
        #1;
        check("s5_rst_key", round_key, 128'd0);
        check("s5_rst_num", {124'd0, round_num}, 128'd0);
        check("s5_rst_flags", {125'd0, key_valid, busy, done}, 128'd0);
        sb_q.delete();
        #1 n_rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("s5_no_done", {126'd0, done, key_valid}, 128'd0);
        end
        clear_seen();
        start_schedule(FIPS_KEY);
        wait_done(cyc);
        check("s5_done_latency", 128'(cyc), 128'd12);
        check("s5_r0", seen_key[0], FIPS_KEY);
        check("s5_r1", seen_key[1], FIPS_R1);
        check("s5_r2", seen_key[2], FIPS_R2);
        check("s5_r10", seen_key[10], FIPS_R10);

        // 6: start during the done pulse.
        start_schedule(ZERO_KEY);
        wait_done(cyc);
        cipher_key = FIPS_KEY;
        start      = 1'b1;
        clear_seen();
        expand_push(FIPS_KEY);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("s6_restart_num", {124'd0, round_num}, 128'd0);
        check("s6_restart_valid_done", {126'd0, key_valid, done}, 128'd2);
        check("s6_restart_key", round_key, FIPS_KEY);
        wait_done(cyc);
        check("s6_r10", seen_key[10], FIPS_R10);
        @(negedge clk);
        check("s6_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
